// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Sources resolve to a committed value, a same-cycle commit bypass, or a pending ROB tag.
module reg_file_rename #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned IDX_W = 5,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned NRP   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic [NRP*IDX_W-1:0] rd_idx,
   output logic [NRP*XLEN-1:0]  rd_value,
   output logic [NRP-1:0]       rd_busy,
   output logic [NRP*TAG_W-1:0] rd_tag,
   input  logic                 issue_valid,
   input  logic [IDX_W-1:0]     issue_rd,
   input  logic [TAG_W-1:0]     issue_tag,
   input  logic                 commit_valid,
   input  logic [IDX_W-1:0]     commit_rd,
   input  logic [TAG_W-1:0]     commit_tag,
   input  logic [XLEN-1:0]      commit_value,
   input  logic                 jump_wrong,
   output logic [IDX_W:0]       busy_cnt
);

   logic [XLEN-1:0]  value_q [NREG];
   logic [XLEN-1:0]  value_d [NREG];
   logic [TAG_W-1:0] tag_q   [NREG];
   logic [TAG_W-1:0] tag_d   [NREG];
   logic [NREG-1:0]  busy_q;
   logic [NREG-1:0]  busy_d;

   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      busy_d  = busy_q;
      // Commit value always lands; busy only clears if no younger rename replaced the tag.
      if (commit_valid && (commit_rd != '0)) begin
         value_d[commit_rd] = commit_value;
         if (tag_q[commit_rd] == commit_tag) begin
            busy_d[commit_rd] = 1'b0;
         end
      end
      if (jump_wrong) begin
         busy_d = '0;
      end else if (issue_valid && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
         tag_d[issue_rd]  = issue_tag;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '{default: '0};
         tag_q   <= '{default: '0};
         busy_q  <= '0;
      end else if (rdy) begin
         value_q <= value_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [IDX_W-1:0] idx;
      logic             bypass;
      logic [XLEN-1:0]  val;
      logic             bsy;
      logic [TAG_W-1:0] tg;

      assign idx    = rd_idx[p*IDX_W +: IDX_W];
      assign bypass = commit_valid && (commit_rd == idx) && busy_q[idx] &&
                      (tag_q[idx] == commit_tag);

      always_comb begin
         val = '0;
         bsy = 1'b0;
         tg  = '0;
         if (idx == '0) begin
            val = '0;
         end else if (bypass) begin
            val = commit_value;
            tg  = tag_q[idx];
         end else begin
            val = value_q[idx];
            bsy = busy_q[idx];
            tg  = tag_q[idx];
         end
      end

      assign rd_value[p*XLEN +: XLEN]  = val;
      assign rd_busy[p]                = bsy;
      assign rd_tag[p*TAG_W +: TAG_W]  = tg;
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < NREG; i++) begin
         busy_cnt = busy_cnt + (IDX_W+1)'(busy_q[i]);
      end
   end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename: rename, commit, bypass, flush, x0, rdy.
module tb_reg_file_rename;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [9:0]  rd_idx;
   logic [63:0] rd_value;
   logic [1:0]  rd_busy;
   logic [7:0]  rd_tag;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_tag;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [3:0]  commit_tag;
   logic [31:0] commit_value;
   logic        jump_wrong;
   logic [5:0]  busy_cnt;

   int n_pass  = 0;
   int n_total = 0;

   reg_file_rename dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .rd_idx       (rd_idx),
      .rd_value     (rd_value),
      .rd_busy      (rd_busy),
      .rd_tag       (rd_tag),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_tag    (issue_tag),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .commit_value (commit_value),
      .jump_wrong   (jump_wrong),
      .busy_cnt     (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid  = 1'b0;
      issue_rd     = '0;
      issue_tag    = '0;
      commit_valid = 1'b0;
      commit_rd    = '0;
      commit_tag   = '0;
      commit_value = '0;
      jump_wrong   = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rdy    = 1'b1;
      rd_idx = {5'd31, 5'd5};
      rst    = 1'b0;
      #2;
      n_total++; if (busy_cnt !== 6'd0) $display("FAIL por_busy_cnt got %0d want 0", busy_cnt); else n_pass++;
      #10 rst = 1'b1;
      tick();
      issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
      commit_valid = 1'b1; commit_rd = 5'd31; commit_value = 32'h1234;
      tick();
      idle();
      #1;
      n_total++; if (busy_cnt !== 6'd1) $display("FAIL traffic_busy_cnt got %0d want 1", busy_cnt); else n_pass++;
      n_total++; if (rd_value[63:32] !== 32'h1234) $display("FAIL traffic_x31 got %h want 00001234", rd_value[63:32]); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (rd_value !== 64'd0) $display("FAIL rst_value got %h want 0", rd_value); else n_pass++;
      n_total++; if (rd_busy !== 2'b00) $display("FAIL rst_busy got %b want 00", rd_busy); else n_pass++;
      n_total++; if (busy_cnt !== 6'd0) $display("FAIL rst_busy_cnt got %0d want 0", busy_cnt); else n_pass++;
      #2 rst = 1'b1;
      tick();
      n_total++; if (rd_value !== 64'd0 || rd_busy !== 2'b00 || rd_tag !== 8'd0)
         $display("FAIL post_rst got v=%h b=%b t=%h want 0", rd_value, rd_busy, rd_tag); else n_pass++;
   endtask

   task automatic test_rename_commit();
      issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd7;
      tick();
      idle();
      rd_idx = {5'd3, 5'd3};
      #1;
      n_total++; if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd7)
         $display("FAIL x3_renamed got b=%b t=%0d want b=1 t=7", rd_busy[0], rd_tag[3:0]); else n_pass++;
      n_total++; if (busy_cnt !== 6'd1) $display("FAIL x3_busy_cnt got %0d want 1", busy_cnt); else n_pass++;
      commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 4'd7; commit_value = 32'hDEADBEEF;
      #1;
      n_total++; if (rd_value[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
         $display("FAIL x3_bypass got v=%h b=%b want deadbeef 0", rd_value[31:0], rd_busy[0]); else n_pass++;
      n_total++; if (rd_value[63:32] !== 32'hDEADBEEF || rd_busy[1] !== 1'b0)
         $display("FAIL x3_bypass_p1 got v=%h b=%b want deadbeef 0", rd_value[63:32], rd_busy[1]); else n_pass++;
      tick();
      idle();
      #1;
      n_total++; if (rd_value[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0)
         $display("FAIL x3_committed got v=%h b=%b c=%0d want deadbeef 0 0", rd_value[31:0], rd_busy[0], busy_cnt); else n_pass++;
   endtask

   task automatic test_stale_commit();
      issue_valid = 1'b1; issue_rd = 5'd4; issue_tag = 4'd2;
      tick();
      issue_tag = 4'd5;
      tick();
      idle();
      rd_idx = {5'd0, 5'd4};
      commit_valid = 1'b1; commit_rd = 5'd4; commit_tag = 4'd2; commit_value = 32'h11;
      #1;
      n_total++; if (rd_value[31:0] !== 32'h0 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd5)
         $display("FAIL stale_no_bypass got v=%h b=%b t=%0d want 0 1 5", rd_value[31:0], rd_busy[0], rd_tag[3:0]); else n_pass++;
      tick();
      idle();
      #1;
      n_total++; if (rd_value[31:0] !== 32'h11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd5)
         $display("FAIL stale_commit got v=%h b=%b t=%0d want 11 1 5", rd_value[31:0], rd_busy[0], rd_tag[3:0]); else n_pass++;
      commit_valid = 1'b1; commit_rd = 5'd4; commit_tag = 4'd5; commit_value = 32'h22;
      #1;
      n_total++; if (rd_value[31:0] !== 32'h22 || rd_busy[0] !== 1'b0)
         $display("FAIL young_bypass got v=%h b=%b want 22 0", rd_value[31:0], rd_busy[0]); else n_pass++;
      tick();
      idle();
      #1;
      n_total++; if (rd_value[31:0] !== 32'h22 || rd_busy[0] !== 1'b0)
         $display("FAIL young_commit got v=%h b=%b want 22 0", rd_value[31:0], rd_busy[0]); else n_pass++;
   endtask

   task automatic test_issue_commit_same();
      issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 4'd1;
      tick();
      commit_valid = 1'b1; commit_rd = 5'd6; commit_tag = 4'd1; commit_value = 32'hAA;
      issue_tag = 4'd9;
      tick();
      idle();
      rd_idx = {5'd0, 5'd6};
      #1;
      n_total++; if (rd_value[31:0] !== 32'hAA || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd9)
         $display("FAIL x6_same_cycle got v=%h b=%b t=%0d want aa 1 9", rd_value[31:0], rd_busy[0], rd_tag[3:0]); else n_pass++;
      commit_valid = 1'b1; commit_rd = 5'd6; commit_tag = 4'd9; commit_value = 32'hBB;
      tick();
      idle();
   endtask

   task automatic test_flush();
      issue_valid = 1'b1;
      for (int r = 1; r <= 3; r++) begin
         issue_rd  = 5'(r);
         issue_tag = 4'(r - 1);
         tick();
      end
      idle();
      #1;
      n_total++; if (busy_cnt !== 6'd3) $display("FAIL pre_flush_cnt got %0d want 3", busy_cnt); else n_pass++;
      jump_wrong = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd8; issue_tag = 4'd4;
      commit_valid = 1'b1; commit_rd = 5'd1; commit_tag = 4'd0; commit_value = 32'h55;
      tick();
      idle();
      rd_idx = {5'd1, 5'd8};
      #1;
      n_total++; if (busy_cnt !== 6'd0) $display("FAIL flush_cnt got %0d want 0", busy_cnt); else n_pass++;
      n_total++; if (rd_busy[0] !== 1'b0) $display("FAIL flush_x8 got b=%b want 0", rd_busy[0]); else n_pass++;
      n_total++; if (rd_value[63:32] !== 32'h55 || rd_busy[1] !== 1'b0)
         $display("FAIL flush_x1 got v=%h b=%b want 55 0", rd_value[63:32], rd_busy[1]); else n_pass++;
   endtask

   task automatic test_x0_rdy();
      issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd3;
      commit_valid = 1'b1; commit_rd = 5'd0; commit_tag = 4'd0; commit_value = 32'h99;
      rd_idx = {5'd0, 5'd0};
      #1;
      n_total++; if (rd_value !== 64'd0 || rd_busy !== 2'b00)
         $display("FAIL x0_same_cycle got v=%h b=%b want 0 00", rd_value, rd_busy); else n_pass++;
      tick();
      idle();
      #1;
      n_total++; if (rd_value !== 64'd0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0)
         $display("FAIL x0_write got v=%h b=%b c=%0d want 0 00 0", rd_value, rd_busy, busy_cnt); else n_pass++;
      issue_valid = 1'b1; issue_rd = 5'd11; issue_tag = 4'd6;
      tick();
      idle();
      rdy = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd8;
      jump_wrong = 1'b1;
      commit_valid = 1'b1; commit_rd = 5'd12; commit_value = 32'h77;
      tick();
      idle();
      rd_idx = {5'd11, 5'd10};
      #1;
      n_total++; if (rd_busy[0] !== 1'b0) $display("FAIL stall_x10 got b=%b want 0", rd_busy[0]); else n_pass++;
      n_total++; if (rd_busy[1] !== 1'b1 || rd_tag[7:4] !== 4'd6)
         $display("FAIL stall_x11 got b=%b t=%0d want 1 6", rd_busy[1], rd_tag[7:4]); else n_pass++;
      rd_idx = {5'd12, 5'd12};
      #1;
      n_total++; if (rd_value !== 64'd0) $display("FAIL stall_x12 got %h want 0", rd_value); else n_pass++;
      rdy = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd8;
      tick();
      idle();
      rd_idx = {5'd10, 5'd10};
      #1;
      n_total++; if (rd_busy !== 2'b11 || rd_tag !== 8'h88)
         $display("FAIL x10_issue got b=%b t=%h want 11 88", rd_busy, rd_tag); else n_pass++;
      n_total++; if (busy_cnt !== 6'd2) $display("FAIL x10_busy_cnt got %0d want 2", busy_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_issue_commit_same();
      test_flush();
      test_x0_rdy();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
Parametrised architectural register file with per-register rename tags for the Tomasulo core. At issue, each source operand is resolved to a committed value or to the ROB tag that will produce it. The destination is renamed to the issuing ROB entry. ROB commits write back, and a mispredict flush discards all pending renames. It sits between decode/issue (RS) and commit (ROB).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers; register 0 is hardwired to zero
IDX_W, 5, register index width (clog2 NREG)
TAG_W, 4, ROB tag width
NRP, 2, number of source read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low, no state changes
rd_idx  in  NRP*IDX_W  source register indices; port p occupies bits [p*IDX_W +: IDX_W]
rd_value  out  NRP*XLEN  committed or bypassed value, per port
rd_busy  out  NRP  1 = operand pending; use rd_tag
rd_tag  out  NRP*TAG_W  ROB tag producing the operand; valid when rd_busy = 1
issue_valid  in  1  rename request this cycle
issue_rd  in  IDX_W  destination register to rename
issue_tag  in  TAG_W  ROB entry assigned to the destination
commit_valid  in  1  ROB commit this cycle
commit_rd  in  IDX_W  committed destination
commit_tag  in  TAG_W  ROB tag of the committing entry
commit_value  in  XLEN  committed result
jump_wrong  in  1  mispredict flush
busy_cnt  out  IDX_W+1  number of currently busy registers

Behaviour:
- Reset (rst = 0, asynchronous):
  - all value[i] = 0, busy[i] = 0, tag[i] = 0.
  - Outputs therefore reset to rd_value = 0, rd_busy = 0, rd_tag = 0, busy_cnt = 0.
  - Reset asserted mid-operation discards all pending renames immediately.
- State updates occur only on a rising clk edge with rst = 1 and rdy = 1. With rdy = 0, all state holds, including flush, issue and commit.
- Reads are combinational with zero latency. Per port p, in priority order:
  - rd_idx = 0 -> value 0, busy 0, tag 0.
  - Else, if commit_valid and commit_rd == rd_idx and busy[rd_idx] and tag[rd_idx] == commit_tag -> bypass: value = commit_value, busy 0.
  - Else -> value[rd_idx], busy[rd_idx], tag[rd_idx].
  - Reads never observe the same-cycle issue rename. An instruction reads its sources before its own destination is renamed.
- Commit, at the clock edge when commit_valid and commit_rd != 0:
  - value[commit_rd] <= commit_value, unconditionally. In-order commit guarantees this is the newest architectural value.
  - busy[commit_rd] <= 0 only if tag[commit_rd] == commit_tag. Otherwise a younger rename is outstanding and busy/tag are kept.
- Issue, at the clock edge when issue_valid, issue_rd != 0 and jump_wrong = 0: busy[issue_rd] <= 1 and tag[issue_rd] <= issue_tag.
- Issue and commit to the same rd in the same cycle: issue wins for busy/tag; the commit value write still happens.
- Flush (jump_wrong = 1):
  - all busy <= 0.
  - Issue in the same cycle is ignored.
  - Commit in the same cycle still writes its value.
  - Tags are left stale; they are ignored while busy = 0.
- Writes targeting register 0 are dropped. busy[0] stays 0.
- busy_cnt is the combinational popcount of the busy vector (0..NREG-1).
- Multiple read ports with the same index return identical results.

Test Plan:
- Reset: hold rst = 0 after random traffic, read x5 and x31 -> value 0, busy 0, busy_cnt 0. Release rst: state still all zero.
- Rename then commit:
  - Issue rd = 3, tag = 7; next cycle read x3 -> busy 1, tag 7, busy_cnt 1.
  - Commit rd = 3, tag = 7, value = 0xDEADBEEF. The same-cycle read gives 0xDEADBEEF with busy 0. Afterwards value = 0xDEADBEEF, busy 0.
- Stale commit: issue x4 with tag 2, then x4 with tag 5. Commit x4, tag 2, value 0x11 -> x4 value 0x11, still busy with tag 5, no bypass on reads. Commit tag 5, value 0x22 -> not busy, value 0x22.
- Simultaneous issue/commit on x6: x6 is busy with tag 1. In one cycle, commit tag 1 value 0xAA and issue tag 9 -> value 0xAA, busy 1, tag 9.
- Flush: rename x1, x2, x3 (busy_cnt 3). Assert jump_wrong with issue x8 tag 4 and commit x1 tag 0 value 0x55 -> busy_cnt 0, x8 not busy, x1 value 0x55.
- x0 and rdy:
  - Issue/commit to x0 -> reads of x0 give 0, not busy.
  - With rdy = 0, issue x10 and flush -> no change.
  - Raise rdy and repeat the issue -> x10 busy.
